// File: rtl/i2cc_multi.sv
// i2cc_multi: I2C write master sending START, 1..NBYTES bytes with ACK
// checking (NACK aborts to STOP), then STOP and a one-cycle done pulse.
module i2cc_multi #(
    parameter int NBYTES = 3,
    parameter int QDIV   = 125
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [8*NBYTES-1:0]          din,
    input  logic [$clog2(NBYTES+1)-1:0]  len,
    input  logic                         wr_i2c,
    output logic                         i2c_sclk,
    inout  wire                          i2c_sdat,
    output logic                         i2c_idle,
    output logic                         i2c_done,
    output logic                         i2c_nack
);

    localparam int W  = 8 * NBYTES;
    localparam int LW = $clog2(NBYTES + 1);
    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} st_t;

    st_t           st;
    logic [CW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitc;
    logic [LW-1:0] bytec;
    logic [W-1:0]  sreg;
    logic          sdal;
    logic          tick;
    logic          sda_in;
    logic [LW-1:0] lenc;

    assign tick     = (qcnt == CW'(QDIV - 1));
    assign lenc     = (len == '0 || len > LW'(NBYTES)) ? LW'(NBYTES) : len;
    assign sda_in   = (i2c_sdat !== 1'b0);
    assign i2c_sdat = sdal ? 1'b0 : 1'bz;

    // Bus levels {scl, pull_low} for a given state and quarter.
    function automatic logic [1:0] pins(st_t s, logic [1:0] qq, logic b);
        case (s)
            START:   pins = {qq != 2'd3, qq[1]};
            BIT:     pins = {qq[1], ~b};
            ACK:     pins = {qq[1], 1'b0};
            STOP:    pins = {qq[1], qq != 2'd3};
            default: pins = 2'b10;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            qcnt     <= '0;
            q        <= '0;
            bitc     <= '0;
            bytec    <= '0;
            sreg     <= '0;
            i2c_sclk <= 1'b1;
            sdal     <= 1'b0;
            i2c_idle <= 1'b1;
            i2c_done <= 1'b0;
            i2c_nack <= 1'b0;
        end else begin
            i2c_done <= 1'b0;
            if (st == IDLE) begin
                qcnt <= '0;
                q    <= '0;
                if (wr_i2c) begin
                    sreg     <= din;
                    bytec    <= lenc;
                    i2c_nack <= 1'b0;
                    i2c_idle <= 1'b0;
                    st       <= START;
                    {i2c_sclk, sdal} <= pins(START, 2'd0, 1'b0);
                end
            end else if (!tick) begin
                qcnt <= qcnt + 1'b1;
            end else begin
                qcnt <= '0;
                q    <= q + 2'd1;
                // Outputs are registered, so load the levels of the next quarter.
                {i2c_sclk, sdal} <= pins(st, q + 2'd1, sreg[W-1]);
                case (st)
                    START: if (q == 2'd3) begin
                        st   <= BIT;
                        bitc <= 3'd7;
                        {i2c_sclk, sdal} <= pins(BIT, 2'd0, sreg[W-1]);
                    end
                    BIT: if (q == 2'd3) begin
                        sreg <= sreg << 1;
                        if (bitc == 3'd0) begin
                            st <= ACK;
                            {i2c_sclk, sdal} <= pins(ACK, 2'd0, 1'b0);
                        end else begin
                            bitc <= bitc - 3'd1;
                            {i2c_sclk, sdal} <= pins(BIT, 2'd0, sreg[W-2]);
                        end
                    end
                    ACK: begin
                        if (q == 2'd2 && sda_in)
                            i2c_nack <= 1'b1;
                        if (q == 2'd3) begin
                            if (i2c_nack || bytec == LW'(1)) begin
                                st <= STOP;
                                {i2c_sclk, sdal} <= pins(STOP, 2'd0, 1'b0);
                            end else begin
                                bytec <= bytec - 1'b1;
                                bitc  <= 3'd7;
                                st    <= BIT;
                                {i2c_sclk, sdal} <= pins(BIT, 2'd0, sreg[W-1]);
                            end
                        end
                    end
                    STOP: if (q == 2'd3) begin
                        st       <= IDLE;
                        i2c_idle <= 1'b1;
                        i2c_done <= 1'b1;
                        {i2c_sclk, sdal} <= pins(IDLE, 2'd0, 1'b0);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2cc_multi.sv
// tb_i2cc_multi: directed bench for i2cc_multi with an ACKing bus slave
// model that records SDA at each SCL rising edge.
module tb_i2cc_multi;

    localparam logic [63:0] FULL_A = 64'({8'hAA, 1'b0, 8'h3C, 1'b0, 8'hC3, 1'b0});
    localparam logic [63:0] FULL_B = 64'({8'h3A, 1'b0, 8'hC3, 1'b0, 8'h3C, 1'b0});
    localparam logic [63:0] NACK_A = 64'({8'hAA, 1'b0, 8'h3C, 1'b1});
    localparam logic [63:0] LEN1_A = 64'({8'hAA, 1'b0});

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] din = '0;
    logic [1:0]  len = '0;
    logic        wr_i2c = 1'b0;
    logic        i2c_sclk;
    logic        i2c_idle;
    logic        i2c_done;
    logic        i2c_nack;
    tri1         sda;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int s0 = 0;
    int p0 = 0;
    bit seen;

    logic        psc = 1'b1;
    logic        psd = 1'b1;
    logic        cur = 1'b0;
    logic        had_rise = 1'b0;
    logic        in_xfer = 1'b0;
    logic        slave_low = 1'b0;
    int          bitn = 0;
    int          byten = 0;
    int          nbits = 0;
    int          nstart = 0;
    int          nstop = 0;
    int          nack_byte = -1;
    logic [63:0] bits = '0;

    i2cc_multi #(.NBYTES(3), .QDIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .len      (len),
        .wr_i2c   (wr_i2c),
        .i2c_sclk (i2c_sclk),
        .i2c_sdat (sda),
        .i2c_idle (i2c_idle),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack)
    );

    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: samples the bus mid-cycle, ACKs every byte except nack_byte.
    always @(negedge clk) begin
        psc <= i2c_sclk;
        psd <= sda;
        if (reset) begin
            slave_low <= 1'b0;
            in_xfer   <= 1'b0;
        end else if (psc && i2c_sclk && psd && !sda) begin
            in_xfer  <= 1'b1;
            nstart   <= nstart + 1;
            bitn     <= 0;
            byten    <= 0;
            nbits    <= 0;
            bits     <= '0;
            had_rise <= 1'b0;
        end else if (psc && i2c_sclk && !psd && sda) begin
            in_xfer <= 1'b0;
            nstop   <= nstop + 1;
        end else if (!psc && i2c_sclk) begin
            cur      <= sda;
            had_rise <= 1'b1;
        end else if (psc && !i2c_sclk && in_xfer && had_rise) begin
            had_rise <= 1'b0;
            bits     <= {bits[62:0], cur};
            nbits    <= nbits + 1;
            if (bitn == 7) begin
                bitn      <= 8;
                slave_low <= (byten != nack_byte);
            end else if (bitn == 8) begin
                bitn      <= 0;
                byten     <= byten + 1;
                slave_low <= 1'b0;
            end else begin
                bitn <= bitn + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [23:0] d, input logic [1:0] l,
                            input int nb);
        @(posedge clk); #1;
        nack_byte = nb;
        din       = d;
        len       = l;
        wr_i2c    = 1'b1;
        @(posedge clk); #1;
        e0     = cyc;
        wr_i2c = 1'b0;
        s0     = nstart;
        p0     = nstop;
        check("idle_low", i2c_idle, 1'b0);
        check("nack_clr", i2c_nack, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc,
                             input logic [63:0] exp_bits, input int exp_n,
                             input logic exp_nack);
        seen = 1'b0;
        while (!seen && (cyc - e0) < 3000) begin
            @(posedge clk); #1;
            seen = i2c_done;
        end
        check({tag, "_done"}, seen, 1'b1);
        check({tag, "_cyc"}, cyc - e0, exp_cyc);
        check({tag, "_idle"}, i2c_idle, 1'b1);
        check({tag, "_nack"}, i2c_nack, exp_nack);
        check({tag, "_bits"}, bits, exp_bits);
        check({tag, "_nbits"}, nbits, exp_n);
        check({tag, "_start"}, nstart - s0, 1);
        check({tag, "_stop"}, nstop - p0, 1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, i2c_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sclk", i2c_sclk, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_idle", i2c_idle, 1'b1);
        check("rst_done", i2c_done, 1'b0);
        check("rst_nack", i2c_nack, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_idle", i2c_idle, 1'b1);

        start_tx(24'hAA3CC3, 2'd3, -1);
        wait_done("full", 464, FULL_A, 27, 1'b0);

        start_tx(24'hAA3CC3, 2'd3, 1);
        wait_done("nack2", 320, NACK_A, 18, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("nack_hold", i2c_nack, 1'b1);

        start_tx(24'hAA3CC3, 2'd1, -1);
        wait_done("len1", 176, LEN1_A, 9, 1'b0);

        start_tx(24'hAA3CC3, 2'd0, -1);
        wait_done("len0", 464, FULL_A, 27, 1'b0);

        start_tx(24'hAA3CC3, 2'd3, -1);
        repeat (100) @(posedge clk);
        #1;
        din    = 24'h3AC33C;
        len    = 2'd1;
        wr_i2c = 1'b1;
        @(posedge clk); #1;
        wr_i2c = 1'b0;
        check("busy_idle", i2c_idle, 1'b0);
        wait_done("busy", 464, FULL_A, 27, 1'b0);

        start_tx(24'h3AC33C, 2'd3, -1);
        wait_done("second", 464, FULL_B, 27, 1'b0);

        @(posedge clk); #1;
        nack_byte = -1;
        din       = 24'hAA3CC3;
        len       = 2'd1;
        wr_i2c    = 1'b1;
        @(posedge clk); #1;
        e0   = cyc;
        seen = 1'b0;
        while (!seen && (cyc - e0) < 3000) begin
            @(posedge clk); #1;
            seen = i2c_done;
        end
        check("b2b_cyc", cyc - e0, 176);
        check("b2b_idle", i2c_idle, 1'b1);
        @(posedge clk); #1;
        e0     = cyc;
        s0     = nstart;
        p0     = nstop;
        wr_i2c = 1'b0;
        check("b2b_restart", i2c_idle, 1'b0);
        wait_done("b2b2", 176, LEN1_A, 9, 1'b0);

        start_tx(24'hAA3CC3, 2'd3, -1);
        repeat (195) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_sclk", i2c_sclk, 1'b1);
        check("mrst_sda", sda, 1'b1);
        check("mrst_idle", i2c_idle, 1'b1);
        check("mrst_done", i2c_done, 1'b0);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("mrst_nodone", i2c_done, 1'b0);
        end
        start_tx(24'hAA3CC3, 2'd3, -1);
        wait_done("after_rst", 464, FULL_A, 27, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2cc_multi.md
# i2cc_multi

Parametrised I2C write master for codec and peripheral configuration; successor to the fixed 24-bit `i2cc`. Sends START, then 1..NBYTES bytes MSB first with an ACK slot after each byte, then STOP, on the open-drain `i2c_sdat`/`i2c_sclk` pair. It adds a variable per-transaction byte count, ACK checking with NACK abort, a sticky error flag, and a completion pulse. It sits between the configuration sequencer, which drives `din`/`wr_i2c`, and the board I2C pins; `i2c_sdat` has an external pull-up.

## Interface
- NBYTES, 3: maximum bytes per transaction (≥1); the default of 3 gives the WM8731 address + 16-bit word.
- QDIV, 125: clk cycles per SCL quarter-period (≥1); 125 gives 100 kHz SCL at 50 MHz.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- din  in  8*NBYTES  payload; byte k is `din[8*NBYTES-1-8k -: 8]`, so byte 0 (slave address) is the top byte.
- len  in  $clog2(NBYTES+1)  bytes to send; 0 or >NBYTES is clamped to NBYTES.
- wr_i2c  in  1  start request; sampled only while idle.
- i2c_sclk  out  1  SCL; driven push-pull.
- i2c_sdat  inout  1  SDA; open-drain, drives 0 or z only; an input value of z/1 reads as 1.
- i2c_idle  out  1  high when no transaction is in progress.
- i2c_done  out  1  one-cycle pulse at transaction end (normal or NACK abort).
- i2c_nack  out  1  sticky: a NACK was seen in the last transaction; cleared when the next transaction is accepted.

## Operation
- Quarter counter qcnt counts 0..QDIV-1; quarter index q (0..3) advances when qcnt wraps. Every non-IDLE state lasts 4 quarters per bit.
- IDLE: sclk=1, sdat=z, idle=1.
  - On wr_i2c=1, latch din into the shift register and the clamped len into the byte counter.
  - Clear nack, reset qcnt and q, go to START.
- START (1 bit-time):
  - q0–q1: SCL 1, SDA z.
  - q2: SCL 1, SDA 0 (START condition).
  - q3: SCL 0, SDA 0.
  - Then BIT with bit counter 7.
- BIT (8 bit-times per byte): SDA = current MSB for the whole bit (0 drives, 1 releases). SCL is 0 in q0–q1 and 1 in q2–q3. Shift left at the end of q3. After bit 0, go to ACK.
- ACK (1 bit-time):
  - SDA released, SCL pattern as in BIT.
  - Sample i2c_sdat on the last cycle of q2.
  - Sample 1: set nack and go to STOP after q3.
  - Sample 0 with bytes remaining: decrement the byte counter and go to BIT.
  - Sample 0 on the last byte: go to STOP.
- STOP (1 bit-time):
  - q0–q1: SCL 0, SDA 0.
  - q2: SCL 1, SDA 0.
  - q3: SCL 1, SDA z (STOP condition).
  - Then IDLE with done=1 for one cycle.
- Boundary conditions:
  - wr_i2c while not idle is ignored; latched data is unaffected by later din/len changes.
  - wr_i2c held high in IDLE starts back-to-back transactions.
  - A NACK on byte k suppresses all later bytes.
  - SDA changes only while SCL is low, except for START and STOP.
  - No clock stretching and no arbitration; SCL is never read.

## Timing
- Reset values: i2c_sclk=1, i2c_sdat=z, i2c_idle=1, i2c_done=0, i2c_nack=0. All counters are cleared and the state is IDLE.
- Reset mid-transaction returns to IDLE on the next edge with no done pulse. The resulting truncated bus cycle is accepted behaviour.
- wr_i2c sampled high at edge E: i2c_idle=0 from E+1.
- Full transaction of N bytes: (8 + 36·N)·QDIV cycles from E+1 until the cycle in which done=1 and idle=1.
- NACK on byte k (1-based): (8 + 36·k)·QDIV cycles.
- i2c_nack is valid no later than the done cycle and holds until the next acceptance.

## Test plan
Bench settings: NBYTES=3, QDIV=4, tri1 pull-up on SDA, bench slave drives SDA low during ACK slots.

- Reset: assert reset for 5 cycles → sclk=1, sdat=z, idle=1, done=0, nack=0.
- Full write: din=0xAA3CC3, len=3, all bytes ACKed.
  - SDA at SCL rising edges: 10101010 0 00111100 0 11000011 0.
  - START and STOP seen; done at 464 cycles after E+1; nack=0.
- NACK on byte 2: slave releases the second ACK slot.
  - Byte 0xC3 is never sent; STOP follows.
  - done at 320 cycles; nack=1 until the next wr_i2c.
- len=1 (also repeat with len=0): len=1 sends only 0xAA, done at 176 cycles; len=0 behaves as len=3.
- Busy write: pulse wr_i2c with din=0x3AC33C mid-transaction.
  - It is ignored and the original 0xAA3CC3 completes.
  - A new wr_i2c after idle then sends 0x3AC33C and clears nack.
- Reset during byte 2: within 1 cycle sclk=1, sdat=z, idle=1, with no done pulse; the next wr_i2c completes normally.
